sp_ram_param: RTL and testbench

// - Parametrised single-port synchronous RAM; next generation of the team's s_ram.
// - Adds byte-lane write enables, a valid/ready request handshake and a 1- or 2-cycle pipelined read.
// - Adds a post-reset/on-demand clear sequencer and out-of-range address error reporting.
// - Local buffer for datapath blocks; one requester per instance.

---
 rtl/sp_ram_pkg.sv | 16 +
 rtl/sp_ram_param_if.sv | 27 ++
 rtl/sp_ram_core.sv | 46 ++++
 rtl/sp_ram_param.sv | 133 +++++++++++++
 tb/tb_sp_ram_param.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the parametrised single-port RAM.
package sp_ram_pkg;

  typedef enum logic {ST_INIT, ST_IDLE} sp_ram_state_e;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  // Merge one byte lane: take the new byte only when its lane enable is set.
  function automatic logic [7:0] be_merge(input logic [7:0] old_b,
                                          input logic [7:0] new_b,
                                          input logic       be_b);
    return be_b ? new_b : old_b;
  endfunction

endpackage

// File: rtl/sp_ram_param_if.sv
// Request/response bundle between a requester and sp_ram_param.
interface sp_ram_param_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic                  clr;
  logic                  en;
  logic                  we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W/8-1:0]   be;
  logic [DATA_W-1:0]     data_in;
  logic                  ready;
  logic [DATA_W-1:0]     data_out;
  logic                  rvalid;
  logic                  err;

  modport master (
    output clr, en, we, addr, be, data_in,
    input  ready, data_out, rvalid, err
  );

  modport slave (
    input  clr, en, we, addr, be, data_in,
    output ready, data_out, rvalid, err
  );
endinterface

// File: rtl/sp_ram_core.sv
// Storage array with byte-lane merged writes and a registered read port.
module sp_ram_core
  import sp_ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_we,
  input  logic                i_re,
  input  logic                i_rzero,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W/8-1:0] i_be,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic [DATA_W-1:0]   o_rdata
);
  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_merged;

  assign w_old = r_mem[i_addr];

  always_comb begin
    w_merged = w_old;
    for (int unsigned i = 0; i < NB; i++) begin
      w_merged[8*i +: 8] = be_merge(w_old[8*i +: 8], i_wdata[8*i +: 8], i_be[i]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= w_merged;
  end

  // Read register only loads on a read, so it holds between responses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_rdata <= '0;
    else if (i_re) r_rdata <= i_rzero ? '0 : r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/sp_ram_param.sv
// Single-port RAM: clear sequencer, range check and 1/2-cycle read pipeline.
module sp_ram_param
  import sp_ram_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  sp_ram_param_if.slave bus
);
  localparam int unsigned NB      = DATA_W / 8;
  localparam int unsigned DEPTH_U = DEPTH;

  generate
    if ((DATA_W % 8) != 0 || READ_LAT < int'(RD_LAT_MIN) || READ_LAT > int'(RD_LAT_MAX))
    begin : g_param_chk
      $fatal(1, "sp_ram_param: DATA_W must be a multiple of 8 and READ_LAT 1 or 2");
    end
  endgenerate

  sp_ram_state_e     r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_init_ptr, w_init_ptr_nxt;
  logic              w_accept, w_in_range, w_last;
  logic              w_core_we, w_core_re;
  logic [ADDR_W-1:0] w_core_addr;
  logic [NB-1:0]     w_core_be;
  logic [DATA_W-1:0] w_core_wdata, w_rdata;
  logic              r_v1, r_e1, r_werr;

  assign w_in_range = 32'(bus.addr) < DEPTH_U;
  assign w_last     = (r_init_ptr == ADDR_W'(DEPTH - 1));
  assign w_accept   = bus.en & bus.ready;
  assign w_core_re  = w_accept & ~bus.we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_INIT;
      r_init_ptr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_ptr <= w_init_ptr_nxt;
    end
  end

  // The clear sequencer owns the core write port while in INIT.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_ptr_nxt = r_init_ptr;
    bus.ready      = 1'b0;
    w_core_we      = 1'b0;
    w_core_addr    = bus.addr;
    w_core_be      = bus.be;
    w_core_wdata   = bus.data_in;
    case (r_state)
      ST_INIT: begin
        w_core_we    = 1'b1;
        w_core_addr  = r_init_ptr;
        w_core_be    = '1;
        w_core_wdata = '0;
        if (w_last) begin
          w_state_nxt    = ST_IDLE;
          w_init_ptr_nxt = '0;
        end else begin
          w_init_ptr_nxt = r_init_ptr + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        bus.ready = 1'b1;
        w_core_we = bus.en & bus.we & w_in_range;
        if (bus.clr) begin
          w_state_nxt    = ST_INIT;
          w_init_ptr_nxt = '0;
        end
      end
    endcase
  end

  sp_ram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_we    (w_core_we),
    .i_re    (w_core_re),
    .i_rzero (~w_in_range),
    .i_addr  (w_core_addr),
    .i_be    (w_core_be),
    .i_wdata (w_core_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1   <= 1'b0;
      r_e1   <= 1'b0;
      r_werr <= 1'b0;
    end else begin
      r_v1   <= w_core_re;
      r_e1   <= w_core_re & ~w_in_range;
      r_werr <= w_accept & bus.we & ~w_in_range;
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              r_v2, r_e2;
      logic [DATA_W-1:0] r_dout;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_v2   <= 1'b0;
          r_e2   <= 1'b0;
          r_dout <= '0;
        end else begin
          r_v2 <= r_v1;
          r_e2 <= r_e1;
          if (r_v1) r_dout <= w_rdata;
        end
      end
      assign bus.rvalid   = r_v2;
      assign bus.err      = r_e2 | r_werr;
      assign bus.data_out = r_dout;
    end else begin : g_lat1
      assign bus.rvalid   = r_v1;
      assign bus.err      = r_e1 | r_werr;
      assign bus.data_out = w_rdata;
    end
  endgenerate
endmodule

// File: tb/tb_sp_ram_param.sv
// Three RAM configurations share one random stimulus stream; a per-instance scoreboard checks every cycle.
module tb_sp_ram_param;
  localparam int NDUT = 3;
  localparam int DEP [NDUT] = '{16, 16, 20};
  localparam int LAT [NDUT] = '{1, 2, 2};
  localparam int AWD [NDUT] = '{4, 4, 5};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        s_rst, s_clr, s_en, s_we;
  logic [4:0]  s_addr;
  logic [3:0]  s_be;
  logic [31:0] s_din;

  sp_ram_param_if #(.DATA_W(32), .DEPTH(16)) ifa ();
  sp_ram_param_if #(.DATA_W(32), .DEPTH(16)) ifb ();
  sp_ram_param_if #(.DATA_W(32), .DEPTH(20)) ifc ();

  assign ifa.clr = s_clr;  assign ifa.en = s_en;  assign ifa.we = s_we;
  assign ifa.addr = s_addr[3:0];  assign ifa.be = s_be;  assign ifa.data_in = s_din;
  assign ifb.clr = s_clr;  assign ifb.en = s_en;  assign ifb.we = s_we;
  assign ifb.addr = s_addr[3:0];  assign ifb.be = s_be;  assign ifb.data_in = s_din;
  assign ifc.clr = s_clr;  assign ifc.en = s_en;  assign ifc.we = s_we;
  assign ifc.addr = s_addr;       assign ifc.be = s_be;  assign ifc.data_in = s_din;

  sp_ram_param #(.DATA_W(32), .DEPTH(16), .READ_LAT(1)) u_a (.clk(clk), .rst(s_rst), .bus(ifa));
  sp_ram_param #(.DATA_W(32), .DEPTH(16), .READ_LAT(2)) u_b (.clk(clk), .rst(s_rst), .bus(ifb));
  sp_ram_param #(.DATA_W(32), .DEPTH(20), .READ_LAT(2)) u_c (.clk(clk), .rst(s_rst), .bus(ifc));

  logic        o_rdy [NDUT];
  logic        o_rv  [NDUT];
  logic        o_er  [NDUT];
  logic [31:0] o_d   [NDUT];
  assign o_rdy[0] = ifa.ready;  assign o_rv[0] = ifa.rvalid;  assign o_er[0] = ifa.err;  assign o_d[0] = ifa.data_out;
  assign o_rdy[1] = ifb.ready;  assign o_rv[1] = ifb.rvalid;  assign o_er[1] = ifb.err;  assign o_d[1] = ifb.data_out;
  assign o_rdy[2] = ifc.ready;  assign o_rv[2] = ifc.rvalid;  assign o_er[2] = ifc.err;  assign o_d[2] = ifc.data_out;

  typedef struct {
    int unsigned due;
    logic        rd;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        q [NDUT][$];
  logic [31:0] mem [NDUT][32];
  int          init_left [NDUT];
  logic [31:0] hold [NDUT];
  int unsigned cyc  = 0;
  int unsigned nchk = 0;
  int unsigned nerr = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      q[k].delete();
      init_left[k] = DEP[k];
      hold[k] = '0;
      for (int a = 0; a < 32; a++) mem[k][a] = '0;
    end
  endtask

  // Effect of one rising edge on each reference RAM, using the inputs it sampled.
  task automatic model_edge();
    int unsigned a;
    logic        inr;
    exp_t        e;
    if (!s_rst) return;
    for (int k = 0; k < NDUT; k++) begin
      if (init_left[k] != 0) begin
        init_left[k]--;
      end else begin
        if (s_en) begin
          a   = int'(s_addr) % (1 << AWD[k]);
          inr = (a < DEP[k]);
          if (s_we) begin
            if (inr) begin
              for (int b = 0; b < 4; b++)
                if (s_be[b]) mem[k][a][8*b +: 8] = s_din[8*b +: 8];
            end else begin
              e = '{due: cyc, rd: 1'b0, err: 1'b1, data: '0};
              q[k].push_back(e);
            end
          end else begin
            e = '{due: cyc + LAT[k] - 1, rd: 1'b1, err: !inr, data: inr ? mem[k][a] : 32'h0};
            q[k].push_back(e);
          end
        end
        if (s_clr) begin
          init_left[k] = DEP[k];
          for (int a2 = 0; a2 < 32; a2++) mem[k][a2] = '0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic req(input logic we, input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    s_en = 1'b1; s_we = we; s_addr = a; s_din = d; s_be = be;
    tick();
    s_en = 1'b0; s_we = 1'b0;
  endtask

  exp_t        m_e;
  logic        m_rv, m_er, m_rdy;
  logic [31:0] m_d;

  always @(negedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      m_rv = 1'b0;
      m_er = 1'b0;
      m_d  = hold[k];
      while (q[k].size() > 0 && q[k][0].due <= cyc) begin
        m_e = q[k].pop_front();
        if (m_e.rd) begin
          m_rv = 1'b1;
          m_d  = m_e.data;
        end
        m_er = m_er | m_e.err;
      end
      m_rdy = s_rst && (init_left[k] == 0);
      chk("ready",    k, o_rdy[k], m_rdy);
      chk("rvalid",   k, o_rv[k],  m_rv);
      chk("err",      k, o_er[k],  m_er);
      chk("data_out", k, o_d[k],   m_d);
      hold[k] = m_d;
    end
  end

  initial begin
    s_rst = 1'b0; s_clr = 1'b0; s_en = 1'b0; s_we = 1'b0;
    s_addr = '0; s_be = '0; s_din = '0;
    model_reset();
    idle(3);
    s_rst = 1'b1;

    // Requests during the power-up clear must be ignored.
    for (int i = 0; i < 8; i++)
      req(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, 4'($urandom));
    idle(20);

    for (int a = 0; a < 16; a++) req(1'b0, 5'(a), '0, '0);

    req(1'b1, 5'd3, 32'hDEADBEEF, 4'hF);
    req(1'b0, 5'd3, '0, '0);
    req(1'b1, 5'd3, 32'h11223344, 4'b0101);
    req(1'b0, 5'd3, '0, '0);
    req(1'b1, 5'd5, 32'h12345678, 4'h0);
    req(1'b0, 5'd5, '0, '0);

    for (int a = 0; a < 4; a++) req(1'b1, 5'(a), 32'hA0 + 32'(a), 4'hF);
    for (int a = 0; a < 4; a++) req(1'b0, 5'(a), '0, '0);

    req(1'b0, 5'd25, '0, '0);
    req(1'b1, 5'd25, 32'hCAFEF00D, 4'hF);
    req(1'b0, 5'd25, '0, '0);
    req(1'b0, 5'd9, '0, '0);
    for (int a = 0; a < 20; a++) req(1'b0, 5'(a), '0, '0);
    idle(3);

    // Reset one cycle after a read is accepted: the read never completes.
    req(1'b1, 5'd3, 32'h55, 4'hF);
    req(1'b0, 5'd3, '0, '0);
    s_rst = 1'b0;
    model_reset();
    idle(2);
    s_rst = 1'b1;
    idle(21);
    req(1'b0, 5'd3, '0, '0);
    idle(3);

    // Same with clr: the in-flight read returns pre-clear data.
    req(1'b1, 5'd3, 32'h55, 4'hF);
    req(1'b0, 5'd3, '0, '0);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    idle(21);
    req(1'b0, 5'd3, '0, '0);
    idle(3);

    for (int i = 0; i < 500; i++) begin
      s_clr  = ($urandom_range(0, 63) == 0);
      s_en   = ($urandom_range(0, 3) != 0);
      s_we   = 1'($urandom_range(0, 1));
      s_addr = 5'($urandom_range(0, 31));
      s_be   = 4'($urandom);
      s_din  = $urandom;
      tick();
    end
    s_en = 1'b0; s_clr = 1'b0;
    idle(5);

    for (int k = 0; k < NDUT; k++) chk("drain", k, 32'(q[k].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
